i2s_master: RTL

//  I2S bus master: drives BCLK/LRCLK from one system clock and carries stereo samples in both

---
 rtl/i2s_master.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2s_master.sv
// Philips I2S bus master: divides the system clock into BCLK/LRCLK, serialises one stereo
// pair per frame onto DOUT through a single holding register and deserialises DIN into rx pairs.
module i2s_master #(
    parameter int CLK_DIV   = 4,
    parameter int SLOT_BITS = 32,
    parameter int TX_WIDTH  = 24,
    parameter int RX_WIDTH  = 16
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [TX_WIDTH-1:0] tx_left_i,
    input  logic [TX_WIDTH-1:0] tx_right_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic [RX_WIDTH-1:0] rx_left_o,
    output logic [RX_WIDTH-1:0] rx_right_o,
    output logic                rx_valid_o,
    output logic                underrun_o,
    output logic                bclk_o,
    output logic                lrclk_o,
    output logic                dout_o,
    input  logic                din_i
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int P_W        = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [P_W-1:0]   P_LAST    = P_W'(FRAME_BITS - 1);
    localparam logic [P_W-1:0]   P_ONE     = P_W'(1);
    localparam logic [P_W-1:0]   LR_FIRST  = P_W'(SLOT_BITS - 1);
    localparam logic [P_W-1:0]   LR_LAST   = P_W'(FRAME_BITS - 2);
    localparam logic [P_W-1:0]   RXL_LAST  = P_W'(RX_WIDTH - 1);
    localparam logic [P_W-1:0]   RXR_FIRST = P_W'(SLOT_BITS);
    localparam logic [P_W-1:0]   RXR_LAST  = P_W'(SLOT_BITS + RX_WIDTH - 1);

    logic [DIV_W-1:0]      div_q, div_d;
    logic                  bclk_q, bclk_d;
    logic [P_W-1:0]        p_q, p_d;
    logic                  lrclk_q, lrclk_d;
    logic                  dout_q, dout_d;
    logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
    logic                  hold_full_q, hold_full_d;
    logic [TX_WIDTH-1:0]   hold_l_q, hold_l_d;
    logic [TX_WIDTH-1:0]   hold_r_q, hold_r_d;
    logic                  underrun_q, underrun_d;
    logic [RX_WIDTH-1:0]   rx_l_sr_q, rx_l_sr_d;
    logic [RX_WIDTH-1:0]   rx_r_sr_q, rx_r_sr_d;
    logic                  started_q, started_d;
    logic [RX_WIDTH-1:0]   rx_left_q, rx_left_d;
    logic [RX_WIDTH-1:0]   rx_right_q, rx_right_d;
    logic                  rx_valid_q, rx_valid_d;

    logic                  tick_s;
    logic                  fall_s;
    logic                  rise_s;
    logic                  frame_start_s;
    logic                  tx_accept_s;
    logic [SLOT_BITS-1:0]  slot_l_s;
    logic [SLOT_BITS-1:0]  slot_r_s;
    logic [FRAME_BITS-1:0] load_word_s;

    assign fall_s      = tick_s & bclk_q;
    assign rise_s      = tick_s & ~bclk_q;
    assign tx_accept_s = tx_valid_i & ~hold_full_q;
    // Samples sit in the slot MSBs; the shift fills the unused LSBs with zeros.
    assign slot_l_s    = SLOT_BITS'(hold_l_q) << (SLOT_BITS - TX_WIDTH);
    assign slot_r_s    = SLOT_BITS'(hold_r_q) << (SLOT_BITS - TX_WIDTH);

    // Clock divider and bit-clock generation.
    always_comb begin
        div_d  = div_q;
        bclk_d = bclk_q;
        tick_s = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
            tick_s = 1'b1;
        end else begin
            div_d  = div_q + DIV_ONE;
        end
    end

    // Frame position advances on each BCLK fall.
    always_comb begin
        p_d           = p_q;
        frame_start_s = 1'b0;
        if (fall_s) begin
            if (p_q == P_LAST) begin
                p_d           = '0;
                frame_start_s = 1'b1;
            end else begin
                p_d           = p_q + P_ONE;
            end
        end else begin
            p_d           = p_q;
        end
    end

    // Transmit path: holding register, frame load/underrun, DOUT and LRCLK.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        tx_sr_d     = tx_sr_q;
        dout_d      = dout_q;
        lrclk_d     = lrclk_q;
        underrun_d  = 1'b0;
        load_word_s = '0;
        if (frame_start_s) begin
            if (hold_full_q) begin
                load_word_s = {slot_l_s, slot_r_s};
                hold_full_d = 1'b0;
            end else begin
                load_word_s = '0;
                underrun_d  = 1'b1;
            end
            dout_d  = load_word_s[FRAME_BITS-1];
            tx_sr_d = FRAME_BITS'({load_word_s, 1'b0});
        end else if (fall_s) begin
            dout_d  = tx_sr_q[FRAME_BITS-1];
            tx_sr_d = FRAME_BITS'({tx_sr_q, 1'b0});
        end else begin
            tx_sr_d = tx_sr_q;
        end
        // LRCLK switches one bit ahead of the slot boundary.
        if (fall_s) begin
            lrclk_d = (p_d >= LR_FIRST) && (p_d <= LR_LAST);
        end else begin
            lrclk_d = lrclk_q;
        end
        // Cannot coincide with a load: a load needs the holding register full.
        if (tx_accept_s) begin
            hold_full_d = 1'b1;
            hold_l_d    = tx_left_i;
            hold_r_d    = tx_right_i;
        end else begin
            hold_full_d = hold_full_d;
        end
    end

    // Receive path: keep only the top RX_WIDTH bits of each slot, publish at frame start.
    always_comb begin
        rx_l_sr_d  = rx_l_sr_q;
        rx_r_sr_d  = rx_r_sr_q;
        started_d  = started_q;
        rx_left_d  = rx_left_q;
        rx_right_d = rx_right_q;
        rx_valid_d = 1'b0;
        if (rise_s && (p_q <= RXL_LAST)) begin
            rx_l_sr_d = RX_WIDTH'({rx_l_sr_q, din_i});
        end else if (rise_s && (p_q >= RXR_FIRST) && (p_q <= RXR_LAST)) begin
            rx_r_sr_d = RX_WIDTH'({rx_r_sr_q, din_i});
        end else begin
            rx_l_sr_d = rx_l_sr_q;
        end
        // The first frame after reset is partial and is dropped.
        if (frame_start_s) begin
            started_d = 1'b1;
            if (started_q) begin
                rx_valid_d = 1'b1;
                rx_left_d  = rx_l_sr_q;
                rx_right_d = rx_r_sr_q;
            end else begin
                rx_valid_d = 1'b0;
            end
        end else begin
            started_d = started_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            p_q         <= P_LAST;
            lrclk_q     <= 1'b0;
            dout_q      <= 1'b0;
            tx_sr_q     <= '0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            underrun_q  <= 1'b0;
            rx_l_sr_q   <= '0;
            rx_r_sr_q   <= '0;
            started_q   <= 1'b0;
            rx_left_q   <= '0;
            rx_right_q  <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            p_q         <= p_d;
            lrclk_q     <= lrclk_d;
            dout_q      <= dout_d;
            tx_sr_q     <= tx_sr_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            underrun_q  <= underrun_d;
            rx_l_sr_q   <= rx_l_sr_d;
            rx_r_sr_q   <= rx_r_sr_d;
            started_q   <= started_d;
            rx_left_q   <= rx_left_d;
            rx_right_q  <= rx_right_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign tx_ready_o = ~hold_full_q;
    assign rx_left_o  = rx_left_q;
    assign rx_right_o = rx_right_q;
    assign rx_valid_o = rx_valid_q;
    assign underrun_o = underrun_q;
    assign bclk_o     = bclk_q;
    assign lrclk_o    = lrclk_q;
    assign dout_o     = dout_q;

endmodule
